// File: rtl/wl_dac_if.sv
// wl_dac_if: config/control bus and DAC/wordline drive signals of the wordline DAC sequencer
interface wl_dac_if #(
  parameter int CODE_W    = 8,
  parameter int NUM_CODES = 8
);
  localparam int AW = $clog2(NUM_CODES);
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [CODE_W-1:0] cfg_wdata;
  logic [AW:0]       num_steps;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step_idx;
  logic              dac_lock_en;
  logic [CODE_W-1:0] dac_data_out;
  logic              wl_pulse_en;
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, num_steps, start, abort,
    input  busy, done, step_idx, dac_lock_en, dac_data_out, wl_pulse_en
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, num_steps, start, abort,
    output busy, done, step_idx, dac_lock_en, dac_data_out, wl_pulse_en
  );
endinterface

// File: rtl/wl_dac_sequencer.sv
// wl_dac_sequencer: steps a DAC code table through lock strobe, settle wait and wordline pulse
module wl_dac_sequencer #(
  parameter int CODE_W        = 8,
  parameter int NUM_CODES     = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int PULSE_CYCLES  = 32
) (
  input logic     sys_clk,
  input logic     sys_rst,
  wl_dac_if.slave bus
);
  localparam int AW = $clog2(NUM_CODES);
  localparam int CW = $clog2((SETTLE_CYCLES > PULSE_CYCLES ? SETTLE_CYCLES : PULSE_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, PULSE, DONE} state_t;
  state_t            state;
  logic [CODE_W-1:0] codes [NUM_CODES];
  logic [AW:0]       steps_lat;
  logic [AW:0]       steps_in;
  logic [CW-1:0]     cnt;
  logic [CODE_W-1:0] first_code;
  logic              last;
  logic              settle_end;
  logic              pulse_end;
  // a write landing in the start cycle must be visible to the first lock
  always_comb begin
    steps_in   = bus.num_steps > (AW+1)'(NUM_CODES) ? (AW+1)'(NUM_CODES) : bus.num_steps;
    first_code = bus.cfg_we && bus.cfg_addr == '0 ? bus.cfg_wdata : codes[0];
    last       = {1'b0, bus.step_idx} == steps_lat - 1'b1;
    settle_end = cnt == CW'(SETTLE_CYCLES - 1);
    pulse_end  = cnt == CW'(PULSE_CYCLES - 1);
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_CODES; i++) codes[i] <= '0;
    end else if (bus.cfg_we && state == IDLE) begin
      codes[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state            <= IDLE;
      steps_lat        <= '0;
      cnt              <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.step_idx     <= '0;
      bus.dac_lock_en  <= 1'b0;
      bus.dac_data_out <= '0;
      bus.wl_pulse_en  <= 1'b0;
    end else begin
      bus.done        <= 1'b0;
      bus.dac_lock_en <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          steps_lat    <= steps_in;
          bus.busy     <= 1'b1;
          bus.step_idx <= '0;
          if (steps_in == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state            <= LOAD;
            bus.dac_lock_en  <= 1'b1;
            bus.dac_data_out <= first_code;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: if (bus.abort) begin
          state           <= IDLE;
          bus.busy        <= 1'b0;
          bus.wl_pulse_en <= 1'b0;
        end else if (state == LOAD) begin
          state <= SETTLE;
          cnt   <= '0;
        end else if (state == SETTLE) begin
          cnt <= settle_end ? '0 : cnt + 1'b1;
          if (settle_end) begin
            state           <= PULSE;
            bus.wl_pulse_en <= 1'b1;
          end
        end else begin
          cnt <= pulse_end ? '0 : cnt + 1'b1;
          if (pulse_end) begin
            bus.wl_pulse_en <= 1'b0;
            if (last) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state            <= LOAD;
              bus.step_idx     <= bus.step_idx + 1'b1;
              bus.dac_lock_en  <= 1'b1;
              bus.dac_data_out <= codes[bus.step_idx + 1'b1];
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wl_dac_sequencer.sv
// tb_wl_dac_sequencer: directed and randomized runs checked against a timeline model of the sequence
module tb_wl_dac_sequencer;
  localparam int S = 16, P = 32, L = 1 + S + P, NC = 8;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;
  wl_dac_if bus ();
  wl_dac_sequencer dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));
  int checks = 0, errors = 0;
  logic [7:0] model [NC];
  logic [7:0] last_data = 8'h00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0;
  endtask
  task automatic wr(input int addr, input logic [7:0] data);
    @(posedge sys_clk); #1;
    clear_inputs();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_wdata = data;
    model[addr] = data;
    @(posedge sys_clk); #1;
    clear_inputs();
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_lock"}, bus.dac_lock_en, 0);
    chk({tag, "_pulse"}, bus.wl_pulse_en, 0);
    chk({tag, "_data"}, bus.dac_data_out, last_data);
  endtask
  // ns: requested steps, abort_k: cycle after start carrying abort (0 = none),
  // noise: random start/cfg_we traffic while busy, wr0: table[0] write in the start cycle
  task automatic run(input int ns, input int abort_k, input bit noise, input bit wr0, input logic [7:0] wv);
    int n, st, ph;
    bit gone;
    logic [7:0] snap [NC];
    @(posedge sys_clk); #1;
    clear_inputs();
    bus.start = 1'b1; bus.num_steps = 4'(ns);
    if (wr0) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_wdata = wv; model[0] = wv;
    end
    n = ns > NC ? NC : ns;
    snap = model;
    for (int k = 1; k <= n * L + 3; k++) begin
      @(posedge sys_clk); #1;
      clear_inputs();
      gone = abort_k != 0 && k > abort_k;
      if (noise && !gone && k <= n * L + 1) begin
        bus.start = 1'($urandom);
        bus.cfg_we = 1'($urandom);
        bus.cfg_addr = k == 5 ? 3'd1 : 3'($urandom);
        bus.cfg_wdata = k == 5 ? 8'hFF : 8'($urandom);
        if (k == 5) bus.cfg_we = 1'b1;
      end
      if (k == abort_k) bus.abort = 1'b1;
      @(negedge sys_clk);
      chk("exclusive", bus.dac_lock_en & bus.wl_pulse_en, 0);
      if (!gone && k <= n * L) begin
        st = (k - 1) / L;
        ph = (k - 1) % L;
        if (ph == 0) last_data = snap[st];
        chk("busy", bus.busy, 1);
        chk("done", bus.done, 0);
        chk("lock", bus.dac_lock_en, ph == 0);
        chk("pulse", bus.wl_pulse_en, ph > S);
        chk("step_idx", bus.step_idx, st);
        chk("data", bus.dac_data_out, last_data);
      end else if (!gone && k == n * L + 1) begin
        chk("done_busy", bus.busy, 1);
        chk("done_pulse", bus.done, 1);
        chk("done_lock", bus.dac_lock_en, 0);
        chk("done_wl", bus.wl_pulse_en, 0);
        chk("done_data", bus.dac_data_out, last_data);
      end else begin
        chk_idle("idle");
      end
    end
    clear_inputs();
  endtask
  initial begin
    int n;
    clear_inputs();
    bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.num_steps = '0;
    for (int i = 0; i < NC; i++) model[i] = 8'h00;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_idle("reset");
    chk("reset_step", bus.step_idx, 0);
    wr(0, 8'h40);
    wr(1, 8'hC0);
    run(2, 0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < NC; i++) wr(i, 8'($urandom));
    run(12, 0, 1'b1, 1'b0, 8'h00);
    run(0, 0, 1'b0, 1'b0, 8'h00);
    run(4, 30, 1'b0, 1'b0, 8'h00);
    run(3, 0, 1'b0, 1'b0, 8'h00);
    @(posedge sys_clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.num_steps = 4'd2;
    repeat (2) begin
      @(posedge sys_clk); #1;
      clear_inputs();
      @(negedge sys_clk);
      chk_idle("abort_start");
    end
    run(1, 0, 1'b0, 1'b1, 8'($urandom));
    @(posedge sys_clk); #1;
    bus.start = 1'b1; bus.num_steps = 4'd1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk); #1;
      clear_inputs();
    end
    @(negedge sys_clk);
    chk("pre_reset_pulse", bus.wl_pulse_en, 1);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    for (int i = 0; i < NC; i++) model[i] = 8'h00;
    last_data = 8'h00;
    @(negedge sys_clk);
    chk_idle("mid_reset");
    run(1, 0, 1'b0, 1'b0, 8'h00);
    repeat (4) begin
      for (int i = 0; i < NC; i++) wr(i, 8'($urandom));
      n = $urandom_range(1, 9);
      run(n, ($urandom_range(0, 1) != 0) ? $urandom_range(1, (n > NC ? NC : n) * L) : 0, 1'b1, 1'b0, 8'h00);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wl_dac_sequencer.md
Name: wl_dac_sequencer

Overview:
- Sequencer for the wordline DAC interface of the 1k array.
- Holds a small table of DAC codes written by the control logic. On `start`, it steps through the table.
- For each step it issues a one-cycle DAC lock strobe with the code, waits a programmable settle time, then asserts the wordline pulse enable for a fixed width.
- Sits between the array controller / config bus and the wordline DAC interface (drives its lock enable and 8-bit data inputs).

Parameters:
- CODE_W, 8, width of one DAC code (matches the DAC interface data width).
- NUM_CODES, 8, depth of the code table (power of 2).
- SETTLE_CYCLES, 16, cycles waited after each lock strobe before pulsing (≥1).
- PULSE_CYCLES, 32, wordline pulse width in cycles (≥1).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  code-table write strobe.
- cfg_addr  in  log2(NUM_CODES)  table entry index.
- cfg_wdata  in  CODE_W  code to write.
- num_steps  in  log2(NUM_CODES)+1  number of table entries to apply, sampled at start.
- start  in  1  begin sequence (level sampled in IDLE).
- abort  in  1  terminate sequence.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- step_idx  out  log2(NUM_CODES)  index of the current step.
- dac_lock_en  out  1  one-cycle strobe to the DAC interface latch.
- dac_data_out  out  CODE_W  code presented to the DAC interface.
- wl_pulse_en  out  1  wordline pulse enable.

Behaviour:
- All outputs are registered.
- Reset (sync, sys_rst=1 at an edge):
  - state=IDLE.
  - All code table entries = 0.
  - busy, done, dac_lock_en, wl_pulse_en = 0.
  - dac_data_out = 0; step_idx = 0.
  - Counters = 0.
  - Reset mid-sequence behaves identically: no done.
- Code table writes:
  - cfg_we=1 in IDLE writes cfg_wdata to entry cfg_addr.
  - cfg_we while busy is ignored (table is frozen during a sequence).
- Sampling at start:
  - steps_lat = min(num_steps, NUM_CODES), latched when start=1 in IDLE.
  - start while busy is ignored.
- FSM states:
  - IDLE:
    - start && steps_lat==0 → DONE (no lock, no pulse).
    - start otherwise → LOAD with idx=0.
  - LOAD (1 cycle):
    - dac_lock_en=1, dac_data_out=table[idx], step_idx=idx.
    - → SETTLE; counter=0.
  - SETTLE: count SETTLE_CYCLES cycles → PULSE.
  - PULSE:
    - wl_pulse_en=1 for exactly PULSE_CYCLES cycles.
    - At the end: if idx==steps_lat-1 → DONE, else idx+1 → LOAD.
  - DONE (1 cycle): done=1 → IDLE.
- Output hold: dac_data_out holds its last value outside LOAD; it only changes in LOAD.
- Timing:
  - start seen at edge T → LOAD at cycle T+1.
  - Per step: 1+SETTLE_CYCLES+PULSE_CYCLES cycles.
  - done at cycle T+1+N·(1+S+P).
  - busy high from T+1 through the DONE cycle inclusive.
- abort:
  - abort=1 in any non-IDLE state → IDLE on the next edge.
  - wl_pulse_en and dac_lock_en go 0 in that cycle; done is never asserted.
  - abort in DONE still lets done complete (DONE already in progress).
- Simultaneous events:
  - abort and start in IDLE: abort has priority; remain IDLE.
  - cfg_we and start in IDLE: the write takes effect; the sequence reads the updated table (LOAD is a cycle later).
- Output invariant: wl_pulse_en and dac_lock_en are never high in the same cycle.

Test Plan:
- Reset/defaults: apply sys_rst mid-PULSE → next cycle wl_pulse_en=0, busy=0, done=0; table reads 0 on a subsequent 1-step run (dac_data_out=0x00).
- Two-step run (S=16, P=32):
  - Stimulus: write table[0]=0x40, table[1]=0xC0; num_steps=2; start at T.
  - Required response: dac_lock_en at T+1 (data 0x40) and at T+50 (data 0xC0); wl_pulse_en high T+18..T+49 and T+67..T+98; done at T+99 only.
- Clamp and zero:
  - num_steps=12 → exactly 8 lock strobes, step_idx 0..7.
  - num_steps=0 → done at T+1, no dac_lock_en, no wl_pulse_en.
- Abort: assert abort at cycle T+30 of a 4-step run → busy=0 at T+31; wl_pulse_en=0 from T+31; no done; next start runs normally from idx 0.
- Ignored inputs while busy:
  - cfg_we to entry 1 (0xFF) during step 0 → step 1 still outputs the original code.
  - start pulses during the run → no restart, same done cycle.
- Priority: abort and start both high in IDLE → stays IDLE, busy=0; cfg_we+start same cycle → the new code appears on dac_data_out at LOAD.
